// File: rtl/datapath.sv
// datapath: 24 x 32-bit register file sharing one 32-bit bus.
// encIn is a one-hot bus-source select; the lowest set bit in 0..23 wins.
// MDR loads either from memory (Read=1) or from the bus.
// Optional macro DATAPATH_R0_ZERO_EN: bus source 0 reads as constant zero.
module datapath (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] Mdatain,
  input  logic [31:0] encIn,
  input  logic        Read,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHIin,
  input  logic        ZLOin,
  input  logic        PCin,
  input  logic        INPORTin,
  input  logic        CSIGNin,
  input  logic        MDRin,
  output logic [31:0] R0,  output logic [31:0] R1,  output logic [31:0] R2,  output logic [31:0] R3,
  output logic [31:0] R4,  output logic [31:0] R5,  output logic [31:0] R6,  output logic [31:0] R7,
  output logic [31:0] R8,  output logic [31:0] R9,  output logic [31:0] R10, output logic [31:0] R11,
  output logic [31:0] R12, output logic [31:0] R13, output logic [31:0] R14, output logic [31:0] R15,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] ZHI,
  output logic [31:0] ZLO,
  output logic [31:0] PC,
  output logic [31:0] MDR,
  output logic [31:0] INPORT,
  output logic [31:0] CSIGN,
  output logic [31:0] busMuxOut
);

  // Register slot numbering matches the encIn bit positions.
  localparam int NREG    = 24;
  localparam int MDR_IDX = 21;

  logic [31:0] r_regs [NREG];
  logic [23:0] w_en;
  logic [4:0]  w_idx;
  logic        w_valid;

  assign w_en = {CSIGNin, INPORTin, MDRin, PCin, ZLOin, ZHIin, LOin, HIin,
                 R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Register file: async clear, otherwise every enabled slot loads the bus
  // (MDR may take memory data instead).
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= 32'h0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_en[i]) begin
          if (i == MDR_IDX && Read) r_regs[i] <= Mdatain;
          else                      r_regs[i] <= busMuxOut;
        end
      end
    end
  end

  // Priority encoder: scanning downward lets the lowest set bit overwrite.
  always_comb begin
    w_idx   = 5'd0;
    w_valid = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (encIn[i]) begin
        w_idx   = i[4:0];
        w_valid = 1'b1;
      end
    end
  end

  // Bus multiplexer: zero when no source in 0..23 is selected.
  always_comb begin
    busMuxOut = 32'h0;
    if (w_valid) busMuxOut = r_regs[w_idx];
`ifdef DATAPATH_R0_ZERO_EN
    if (w_valid && w_idx == 5'd0) busMuxOut = 32'h0;
`else
`endif
  end

  assign R0  = r_regs[0];  assign R1  = r_regs[1];  assign R2  = r_regs[2];  assign R3  = r_regs[3];
  assign R4  = r_regs[4];  assign R5  = r_regs[5];  assign R6  = r_regs[6];  assign R7  = r_regs[7];
  assign R8  = r_regs[8];  assign R9  = r_regs[9];  assign R10 = r_regs[10]; assign R11 = r_regs[11];
  assign R12 = r_regs[12]; assign R13 = r_regs[13]; assign R14 = r_regs[14]; assign R15 = r_regs[15];
  assign HI     = r_regs[16];
  assign LO     = r_regs[17];
  assign ZHI    = r_regs[18];
  assign ZLO    = r_regs[19];
  assign PC     = r_regs[20];
  assign MDR    = r_regs[21];
  assign INPORT = r_regs[22];
  assign CSIGN  = r_regs[23];

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed vector table, reset sequences, random traffic
// against a register-array reference model.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] Mdatain = 32'h0;
  logic [31:0] encIn = 32'h0;
  logic        Read = 1'b0;
  logic [23:0] en = 24'h0;
  logic [31:0] q [24];
  logic [31:0] busMuxOut;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: one word per register slot.
  logic [31:0] m [24];

  always #5 Clock = ~Clock;

  datapath dut (
    .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain), .encIn(encIn), .Read(Read),
    .R0in(en[0]), .R1in(en[1]), .R2in(en[2]), .R3in(en[3]),
    .R4in(en[4]), .R5in(en[5]), .R6in(en[6]), .R7in(en[7]),
    .R8in(en[8]), .R9in(en[9]), .R10in(en[10]), .R11in(en[11]),
    .R12in(en[12]), .R13in(en[13]), .R14in(en[14]), .R15in(en[15]),
    .HIin(en[16]), .LOin(en[17]), .ZHIin(en[18]), .ZLOin(en[19]),
    .PCin(en[20]), .INPORTin(en[22]), .CSIGNin(en[23]), .MDRin(en[21]),
    .R0(q[0]), .R1(q[1]), .R2(q[2]), .R3(q[3]),
    .R4(q[4]), .R5(q[5]), .R6(q[6]), .R7(q[7]),
    .R8(q[8]), .R9(q[9]), .R10(q[10]), .R11(q[11]),
    .R12(q[12]), .R13(q[13]), .R14(q[14]), .R15(q[15]),
    .HI(q[16]), .LO(q[17]), .ZHI(q[18]), .ZLO(q[19]),
    .PC(q[20]), .MDR(q[21]), .INPORT(q[22]), .CSIGN(q[23]),
    .busMuxOut(busMuxOut)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus value from the selection rule: isolate the lowest set bit of the
  // low 24 bits, then find which register that bit names.
  function automatic logic [31:0] model_bus(input logic [31:0] enc);
    logic [23:0] low, iso;
    low = enc[23:0];
    if (low == 24'h0) return 32'h0;
    iso = low & (~low + 24'h1);
`ifdef DATAPATH_R0_ZERO_EN
    if (iso == 24'h1) return 32'h0;
`endif
    for (int k = 0; k < 24; k++)
      if (iso == (24'h1 << k)) return m[k];
    return 32'hx;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 24; k++) m[k] = 32'h0;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 24; k++) chk($sformatf("%s_reg%0d", tag, k), q[k], m[k]);
  endtask

  // One clock: apply inputs, check the bus before the edge, update the
  // model with that bus value, check registers after the edge.
  task automatic step(input logic [31:0] e, input logic [23:0] le, input logic rd,
                      input logic [31:0] md, input string tag);
    logic [31:0] b;
    encIn = e; en = le; Read = rd; Mdatain = md;
    #1;
    b = model_bus(e);
    chk({tag, "_bus"}, busMuxOut, b);
    @(posedge Clock);
    for (int k = 0; k < 24; k++)
      if (le[k]) m[k] = (k == 21 && rd) ? md : b;
    #1;
    check_all(tag);
    @(negedge Clock);
  endtask

  typedef struct {
    logic [31:0] enc;
    logic [23:0] le;
    logic        rd;
    logic [31:0] md;
    logic [31:0] exp_bus;
    int          idx;
    logic [31:0] exp_val;
  } vec_t;

  localparam logic [31:0] SEL_MDR = 32'h0020_0000;
  localparam logic [31:0] SEL_PC  = 32'h0010_0000;
`ifdef DATAPATH_R0_ZERO_EN
  localparam logic [31:0] R0_BUS = 32'h0;
`else
  localparam logic [31:0] R0_BUS = 32'h12;
`endif

  vec_t vt [13];

  initial begin
    vt[0]  = '{32'h0,        24'h200000, 1'b1, 32'h12,       32'h0,  21, 32'h12};
    vt[1]  = '{SEL_MDR,      24'h000001, 1'b0, 32'h0,        32'h12, 0,  32'h12};
    vt[2]  = '{32'h0,        24'h200000, 1'b1, 32'hA,        32'h0,  21, 32'hA};
    vt[3]  = '{SEL_MDR,      24'h000008, 1'b0, 32'h0,        32'hA,  3,  32'hA};
    vt[4]  = '{32'h0,        24'h200000, 1'b1, 32'hB,        32'h0,  21, 32'hB};
    vt[5]  = '{SEL_MDR,      24'h000080, 1'b0, 32'h0,        32'hB,  7,  32'hB};
    vt[6]  = '{32'h88,       24'h000000, 1'b0, 32'h0,        32'hA,  3,  32'hA};
    vt[7]  = '{32'h01000000, 24'h000000, 1'b0, 32'h0,        32'h0,  7,  32'hB};
    vt[8]  = '{32'h0,        24'h200000, 1'b1, 32'h40,       32'h0,  21, 32'h40};
    vt[9]  = '{SEL_MDR,      24'h100000, 1'b0, 32'h0,        32'h40, 20, 32'h40};
    vt[10] = '{SEL_PC,       24'hA30000, 1'b0, 32'hFFFFFFFF, 32'h40, 23, 32'h40};
    vt[11] = '{32'h1,        24'h000000, 1'b0, 32'h0,        R0_BUS, 0,  32'h12};
    vt[12] = '{32'h8,        24'h000008, 1'b0, 32'h0,        32'hA,  3,  32'hA};
  end

  initial begin
    #20000;
    $display("FAIL watchdog: sim time %0t exceeded limit %0d", $time, 20000);
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    model_clear();
    // Power-up in reset.
    @(negedge Clock);
    #1;
    check_all("reset");
    chk("reset_bus", busMuxOut, 32'h0);
    Clear = 1'b1;
    @(negedge Clock);

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      encIn = vt[i].enc; en = vt[i].le; Read = vt[i].rd; Mdatain = vt[i].md;
      #1;
      chk($sformatf("vec%0d_bus", i), busMuxOut, vt[i].exp_bus);
      step(vt[i].enc, vt[i].le, vt[i].rd, vt[i].md, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_target", i), q[vt[i].idx], vt[i].exp_val);
    end
    chk("multi_hi", q[16], 32'h40);
    chk("multi_lo", q[17], 32'h40);
    chk("multi_mdr", q[21], 32'h40);

    // Async clear mid-cycle with R5 holding data, no clock edge involved.
    step(32'h0, 24'h200000, 1'b1, 32'hDEADBEEF, "ld_mdr");
    step(SEL_MDR, 24'h000020, 1'b0, 32'h0, "ld_r5");
    chk("r5_loaded", q[5], 32'hDEADBEEF);
    encIn = 32'h20; en = 24'h0;
    #2;
    Clear = 1'b0;
    #1;
    model_clear();
    check_all("aclr");
    chk("aclr_r5", q[5], 32'h0);
    chk("aclr_bus", busMuxOut, 32'h0);
    // Clear overrides loads across an edge.
    Mdatain = 32'h5555AAAA; Read = 1'b1; en = 24'hFFFFFF;
    @(posedge Clock);
    #1;
    check_all("clr_prio");
    @(negedge Clock);
    en = 24'h0;
    Clear = 1'b1;
    step(32'h0, 24'h200000, 1'b1, 32'h77, "resume");
    chk("resume_mdr", q[21], 32'h77);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: e = 32'h1 << $urandom_range(23);
        1: e = $urandom;
        2: e = {$urandom_range(255), 24'h0};
        default: e = (32'h1 << $urandom_range(23)) | (32'h1 << $urandom_range(23));
      endcase
      step(e, 24'($urandom) & 24'($urandom), 1'($urandom), $urandom, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
